// File: rtl/req_encoder_if.sv
// Request/grant bundle for req_encoder: request lines in, one binary code out over valid/ready.
// The slave modport is the encoder's view; the master modport is the requester/consumer side.
interface req_encoder_if #(
   parameter int N_REQ  = 4,
   parameter int CODE_W = 2
);
   logic [N_REQ-1:0]  req_in;
   logic [CODE_W-1:0] out_code;
   logic              out_valid;
   logic              out_ready;
   logic [N_REQ-1:0]  pending;

   modport slave (
      input  req_in,
      input  out_ready,
      output out_code,
      output out_valid,
      output pending
   );

   modport master (
      output req_in,
      output out_ready,
      input  out_code,
      input  out_valid,
      input  pending
   );
endinterface

// File: rtl/req_encoder.sv
// Sequential N-to-log2(N) encoder: sticky pending requests leave one code per handshake.
// Optional macro REQ_ENCODER_ROUND_ROBIN_EN swaps fixed priority for round-robin arbitration.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | nothing presented, waiting for a request
// PRESENT | out_code/out_valid held until the consumer accepts
module req_encoder #(
   parameter int N_REQ  = 4,
   parameter int CODE_W = 2
) (
   input logic           clk,
   input logic           rst,
   req_encoder_if.slave  bus
);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t            state, state_nx;
   logic [N_REQ-1:0]  pending_q, pending_nx, clr_mask;
   logic [CODE_W-1:0] code_q, code_nx, sel_code;
   logic              valid_q, valid_nx, accept;

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
   logic [CODE_W-1:0] last_q, last_nx, ptr;

   // Scan downward from ptr-1 with wrap; the k=0 candidate is assigned last and so wins.
   function automatic logic [CODE_W-1:0] sel(input logic [N_REQ-1:0] c,
                                             input logic [CODE_W-1:0] p);
      logic [CODE_W-1:0] idx;
      sel = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = p - CODE_W'(1) - CODE_W'(k);
         if (c[idx]) sel = idx;
      end
   endfunction
`else
   // Fixed priority: the highest set index overwrites lower ones.
   function automatic logic [CODE_W-1:0] sel(input logic [N_REQ-1:0] c);
      sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (c[i]) sel = CODE_W'(i);
      end
   endfunction
`endif

   always_comb begin
      accept     = valid_q & bus.out_ready;
      clr_mask   = accept ? (N_REQ'(1) << code_q) : '0;
      // In IDLE this equals pending|req_in since nothing is being cleared.
      pending_nx = (pending_q & ~clr_mask) | bus.req_in;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
      // The code being accepted becomes the pointer immediately so it ranks lowest next.
      ptr      = accept ? code_q : last_q;
      last_nx  = ptr;
      sel_code = sel(pending_nx, ptr);
`else
      sel_code = sel(pending_nx);
`endif
      state_nx = state;
      code_nx  = code_q;
      valid_nx = valid_q;
      case (state)
         IDLE: begin
            if (pending_nx != '0) begin
               code_nx  = sel_code;
               valid_nx = 1'b1;
               state_nx = PRESENT;
            end
         end
         PRESENT: begin
            if (accept) begin
               if (pending_nx != '0) begin
                  code_nx = sel_code;
               end else begin
                  valid_nx = 1'b0;
                  state_nx = IDLE;
               end
            end
         end
         default: begin
            valid_nx = 1'b0;
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pending_q <= '0;
         code_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         state     <= state_nx;
         pending_q <= pending_nx;
         code_q    <= code_nx;
         valid_q   <= valid_nx;
      end
   end

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_q <= '0;
      else     last_q <= last_nx;
   end
`endif

   assign bus.out_code  = code_q;
   assign bus.out_valid = valid_q;
   assign bus.pending   = pending_q;

endmodule

// File: tb/tb_req_encoder.sv
// Bench for req_encoder: directed scenarios with literal expectations plus random traffic
// compared every cycle against a set-based model of the pending requests and presented code.
module tb_req_encoder;

   localparam int N = 4;
   localparam int W = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   req_encoder_if #(.N_REQ(N), .CODE_W(W)) bus ();

   req_encoder #(.N_REQ(N), .CODE_W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   bit       m_pend [N];
   bit       m_valid;
   int       m_code;
   int       m_last;

   function automatic int pend_bits();
      int v = 0;
      for (int i = 0; i < N; i++) if (m_pend[i]) v += (1 << i);
      return v;
   endfunction

   function automatic bit any_pend();
      return pend_bits() != 0;
   endfunction

   // Grant choice from the set of pending lines.
   function automatic int pick();
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
      for (int k = 1; k <= N; k++) begin
         int idx = (m_last - k + 2 * N) % N;
         if (m_pend[idx]) return idx;
      end
      return 0;
`else
      for (int i = N - 1; i >= 0; i--) if (m_pend[i]) return i;
      return 0;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_valid = 1'b0;
      m_code  = 0;
      m_last  = 0;
   endtask

   task automatic model_step(input logic [N-1:0] r, input logic rdy);
      bit acc = m_valid && rdy;
      if (acc) begin
         m_pend[m_code] = 1'b0;
         m_last = m_code;
      end
      for (int i = 0; i < N; i++) if (r[i]) m_pend[i] = 1'b1;
      if (!m_valid || acc) begin
         if (any_pend()) begin
            m_valid = 1'b1;
            m_code  = pick();
         end else begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic lit(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (!rst) begin
         vectors++;
         if (bus.out_valid !== m_valid || bus.pending !== N'(pend_bits()) ||
             (m_valid && bus.out_code !== W'(m_code))) begin
            miscompares++;
            $display("FAIL model_cmp t=%0t: valid=%0b code=%0d pending=%b, expected valid=%0b code=%0d pending=%b",
                     $time, bus.out_valid, bus.out_code, bus.pending, m_valid, m_code, N'(pend_bits()));
         end
      end
   end

   task automatic step(input logic [N-1:0] r, input logic rdy);
      bus.req_in    = r;
      bus.out_ready = rdy;
      @(posedge clk);
      model_step(r, rdy);
      @(negedge clk);
   endtask

   task automatic async_reset();
      rst = 1'b1;
      model_reset();
      #1;
      lit("rst_valid",   int'(bus.out_valid), 0);
      lit("rst_code",    int'(bus.out_code), 0);
      lit("rst_pending", int'(bus.pending), 0);
      bus.req_in    = '0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bus.req_in    = '0;
      bus.out_ready = 1'b0;
      model_reset();
      #2;
      async_reset();

      // single pulse, 1-cycle latency
      step(4'b0100, 1'b1);
      lit("t1_valid", int'(bus.out_valid), 1);
      lit("t1_code",  int'(bus.out_code), 2);
      step(4'b0000, 1'b1);
      lit("t1_idle",  int'(bus.out_valid), 0);
      lit("t1_pend",  int'(bus.pending), 0);

      // several requests drain in priority order without bubbles
      step(4'b1011, 1'b1);
      lit("t2_c3", int'(bus.out_code), 3);
      step(4'b0000, 1'b1);
      lit("t2_c1", int'(bus.out_code), 1);
      step(4'b0000, 1'b1);
      lit("t2_c0", int'(bus.out_code), 0);
      lit("t2_v0", int'(bus.out_valid), 1);
      step(4'b0000, 1'b1);
      lit("t2_end", int'(bus.out_valid), 0);

      // presented code is not replaced by a higher request
      step(4'b0001, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b1000, 1'b0);
      lit("t3_hold", int'(bus.out_code), 0);
      lit("t3_pend", int'(bus.pending), 9);
      step(4'b0000, 1'b0);
      lit("t3_hold2", int'(bus.out_code), 0);
      step(4'b0000, 1'b1);
      lit("t3_next", int'(bus.out_code), 3);
      step(4'b0000, 1'b1);
      lit("t3_end", int'(bus.out_valid), 0);

      // re-request in the accept cycle re-issues the code
      step(4'b0100, 1'b0);
      step(4'b0100, 1'b1);
      lit("t4_again", int'(bus.out_code), 2);
      lit("t4_valid", int'(bus.out_valid), 1);
      lit("t4_pend",  int'(bus.pending), 4);
      step(4'b0000, 1'b1);
      lit("t4_end", int'(bus.out_valid), 0);

      // reset mid-transfer
      step(4'b0110, 1'b0);
      lit("t5_pend", int'(bus.pending), 6);
      #2;
      async_reset();
      for (int i = 0; i < 3; i++) begin
         step(4'b0000, 1'b1);
         lit("t5_quiet", int'(bus.out_valid), 0);
      end

      // all lines held high
      begin
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
         int exp_seq [6] = '{3, 2, 1, 0, 3, 2};
`else
         int exp_seq [6] = '{3, 3, 3, 3, 3, 3};
`endif
         for (int i = 0; i < 6; i++) begin
            step(4'b1111, 1'b1);
            lit("t6_seq", int'(bus.out_code), exp_seq[i]);
         end
      end
      for (int i = 0; i < 6; i++) step(4'b0000, 1'b1);
      lit("t6_drain", int'(bus.out_valid), 0);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         logic [N-1:0] r;
         logic rdy;
         r   = ($urandom_range(0, 3) == 0) ? N'($urandom_range(1, (1 << N) - 1)) : '0;
         rdy = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 399) == 0) begin
            #2;
            async_reset();
         end
         step(r, rdy);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/req_encoder.md
Name: req_encoder

Overview:
- Sequential 4-to-2 encoder: the inverse of the team's 2-to-4 one-hot decoder.
- Collects request lines into a sticky pending register and emits one binary code per pending request.
- Codes leave in priority order over a valid/ready handshake, so a downstream 2-to-4 decoder stage or consumer FSM can service them one at a time.

Parameters:
- N_REQ, 4, number of request lines; power of two, at least 2.
- CODE_W, 2, width of out_code; must equal log2(N_REQ).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_in  input  N_REQ  request lines, level-sampled each clk edge; bit i requests code i.
- out_code  output  CODE_W  binary index of the granted request.
- out_valid  output  1  out_code holds a valid code.
- out_ready  input  1  consumer accepts out_code this cycle.
- pending  output  N_REQ  current sticky pending register, for status.

Behaviour:
- Reset (async assert, sync release): pending=0, out_valid=0, out_code=0, state=IDLE, rr pointer=0. A reset in the middle of a transfer drops the presented code and all pending bits; no code is emitted after release until req_in is sampled again.
- Pending update every edge: pending_next = (pending & ~clr_mask) | req_in.
  - clr_mask is the one-hot of out_code when out_valid & out_ready, else 0.
  - If req_in bit i is high in the same cycle that code i is accepted, bit i stays set and is re-issued later.
- FSM states: IDLE and PRESENT.
- IDLE:
  - cand = pending | req_in.
  - If cand != 0: register out_code = sel(cand), out_valid=1, go to PRESENT.
  - Result: out_valid rises on the edge after req_in is first sampled, i.e. 1-cycle latency.
- PRESENT, not accepted (out_valid & ~out_ready):
  - out_code and out_valid are held stable.
  - New or higher-priority requests only accumulate in pending; they never replace the presented code.
- PRESENT, accepted (out_valid & out_ready):
  - rem = (pending & ~clr_mask) | req_in.
  - If rem != 0: load out_code = sel(rem) and stay in PRESENT. This gives back-to-back grants with no bubble: one code per cycle while out_ready=1.
  - Else: out_valid=0, go to IDLE. out_code keeps its last value.
- sel() in the default build is fixed priority: the highest set index wins (bit N_REQ-1 highest, bit 0 lowest).
- out_code is only meaningful while out_valid=1.
- A request held high continuously is re-granted after every acceptance. Bench and consumer must treat req_in as a pulse or a clear-on-service level.
- All outputs are registered; there is no combinational path from req_in or out_ready to any output.

Optional Feature:
- Macro: REQ_ENCODER_ROUND_ROBIN_EN.
- Defined:
  - A CODE_W-bit pointer `last` is loaded with out_code on each acceptance (reset value 0).
  - sel() scans from index (last-1) mod N_REQ downward, wrapping, and picks the first set bit. The just-granted line becomes lowest priority.
  - With last=0 after reset, the first grant matches fixed priority.
- Not defined: the pointer logic is absent and sel() is fixed priority as above.

Test Plan:
1. Reset, then pulse req_in=4'b0100 for 1 cycle with out_ready=1 -> next cycle out_valid=1, out_code=2'd2. Following cycle out_valid=0, pending=0.
2. req_in=4'b1011 for 1 cycle, out_ready=1 throughout -> codes 3, 1, 0 on three consecutive cycles, then out_valid=0.
3. req_in=4'b0001 pulse with out_ready=0; 2 cycles later pulse req_in=4'b1000 -> out_code stays 0 with out_valid=1 until out_ready rises. Then code 0 is accepted, followed by code 3 on the next cycle.
4. Code 2 presented; in its accept cycle req_in=4'b0100 again -> pending[2] stays set and code 2 is emitted a second time.
5. Assert rst while out_valid=1 with pending=4'b0110 -> out_valid, out_code and pending go to 0 immediately (asynchronously). Nothing is emitted after release with req_in=0.
6. REQ_ENCODER_ROUND_ROBIN_EN defined, req_in held at 4'b1111, out_ready=1 -> code sequence 3, 2, 1, 0, 3, 2, ... Without the macro, the sequence is 3, 3, 3, ...
